// File: rtl/clkdiv_counter.sv
// Free-running binary up-counter providing power-of-two divided clocks,
// per-bit rise strobes and a registered roll-over pulse.
module clkdiv_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] clkdiv,
  output logic [WIDTH-1:0] tick,
  output logic             wrap
);

  generate
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("clkdiv_counter: WIDTH must be in 2..64");
    end
  endgenerate

  logic [WIDTH-1:0] count_next;

  // Wide counters: each 8-bit segment precomputes its +1 value in parallel,
  // and a wide AND of all lower bits selects it, keeping the path short.
  generate
    if (WIDTH > 16) begin : g_csel
      localparam int NSEG = (WIDTH + 7) / 8;
      for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int LO = k * 8;
        localparam int SW = ((WIDTH - LO) < 8) ? (WIDTH - LO) : 8;
        logic          cin;
        logic [SW-1:0] seg_inc;
        if (k == 0) begin : g_c0
          assign cin = 1'b1;
        end else begin : g_cn
          assign cin = &clkdiv[LO-1:0];
        end
        assign seg_inc              = clkdiv[LO +: SW] + SW'(1);
        assign count_next[LO +: SW] = cin ? seg_inc : clkdiv[LO +: SW];
      end
    end else begin : g_plain
      assign count_next = clkdiv + WIDTH'(1);
    end
  endgenerate

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_tick
      if (i == 0) begin : g_t0
        assign tick[0] = clkdiv[0];
      end else begin : g_tn
        assign tick[i] = clkdiv[i] & ~(|clkdiv[i-1:0]);
      end
    end
  endgenerate

  // wrap is set on the edge that rolls all-ones over to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkdiv <= '0;
      wrap   <= 1'b0;
    end else begin
      clkdiv <= count_next;
      wrap   <= &clkdiv;
    end
  end

endmodule

// File: tb/tb_clkdiv_counter.sv
// Directed self-checking bench for clkdiv_counter at WIDTH 32, 8 and 4.
module tb_clkdiv_counter;

  logic        clk = 1'b0;
  logic        rst32, rst8, rst4;
  logic [31:0] cd32, tk32;
  logic        wr32;
  logic [7:0]  cd8, tk8;
  logic        wr8;
  logic [3:0]  cd4, tk4;
  logic        wr4;

  int total = 0;
  int bad   = 0;

  logic [3:0] tk_tab [10];

  clkdiv_counter #(.WIDTH(32)) u32 (.clk(clk), .rst(rst32), .clkdiv(cd32), .tick(tk32), .wrap(wr32));
  clkdiv_counter #(.WIDTH(8))  u8  (.clk(clk), .rst(rst8),  .clkdiv(cd8),  .tick(tk8),  .wrap(wr8));
  clkdiv_counter #(.WIDTH(4))  u4  (.clk(clk), .rst(rst4),  .clkdiv(cd4),  .tick(tk4),  .wrap(wr4));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at edge+1: pulse reset low between edges.
  task automatic reset_all();
    rst32 = 1'b0; rst8 = 1'b0; rst4 = 1'b0;
    #2;
    rst32 = 1'b1; rst8 = 1'b1; rst4 = 1'b1;
  endtask

  task automatic test_reset();
    rst32 = 1'b0; rst8 = 1'b0; rst4 = 1'b0;
    repeat (3) step();
    total++;
    if (cd32 !== 32'h0 || tk32 !== 32'h0 || wr32 !== 1'b0) begin
      bad++;
      $display("FAIL reset32 clkdiv=%h tick=%h wrap=%b required 0/0/0", cd32, tk32, wr32);
    end
    total++;
    if (cd8 !== 8'h0 || tk8 !== 8'h0 || wr8 !== 1'b0) begin
      bad++;
      $display("FAIL reset8 clkdiv=%h tick=%h wrap=%b required 0/0/0", cd8, tk8, wr8);
    end
    total++;
    if (cd4 !== 4'h0 || tk4 !== 4'h0 || wr4 !== 1'b0) begin
      bad++;
      $display("FAIL reset4 clkdiv=%h tick=%h wrap=%b required 0/0/0", cd4, tk4, wr4);
    end
  endtask

  task automatic test_count10();
    tk_tab = '{4'h1, 4'h2, 4'h1, 4'h4, 4'h1, 4'h2, 4'h1, 4'h8, 4'h1, 4'h2};
    reset_all();
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (cd32 !== 32'(k)) begin
        bad++;
        $display("FAIL count10 clkdiv got=%0d want=%0d", cd32, k);
      end
      total++;
      if (tk32 !== {28'h0, tk_tab[k-1]}) begin
        bad++;
        $display("FAIL count10_tick at %0d got=%h want=%h", k, tk32, tk_tab[k-1]);
      end
      total++;
      if (wr32 !== 1'b0) begin
        bad++;
        $display("FAIL count10_wrap at %0d got=%b want=0", k, wr32);
      end
    end
  endtask

  task automatic test_period();
    logic p0, p3;
    int   last_edge, toggles, high_cnt;
    logic ok0, ok_int;
    reset_all();
    p0 = 1'b0; p3 = 1'b0;
    last_edge = 0; toggles = 0; high_cnt = 0;
    ok0 = 1'b1; ok_int = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      step();
      if (cd32[0] === p0) ok0 = 1'b0;
      p0 = cd32[0];
      if (cd32[3] !== p3) begin
        toggles++;
        if (n - last_edge != 8) ok_int = 1'b0;
        last_edge = n;
      end
      p3 = cd32[3];
      if (cd32[3] === 1'b1) high_cnt++;
    end
    total++;
    if (!ok0) begin
      bad++;
      $display("FAIL period_bit0 toggled every cycle got=0 want=1");
    end
    total++;
    if (!ok_int || toggles != 8) begin
      bad++;
      $display("FAIL period_bit3 toggles=%0d uniform8=%b want toggles=8 uniform8=1", toggles, ok_int);
    end
    total++;
    if (high_cnt != 32) begin
      bad++;
      $display("FAIL period_bit3_duty high=%0d want=32", high_cnt);
    end
  endtask

  task automatic test_mid_reset();
    reset_all();
    for (int n = 1; n <= 32'h1234; n++) begin
      step();
      total++;
      if (cd32 !== 32'(n)) begin
        bad++;
        $display("FAIL run1234 got=%h want=%h", cd32, n);
      end
    end
    rst32 = 1'b0;
    #1;
    total++;
    if (cd32 !== 32'h0 || tk32 !== 32'h0 || wr32 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset clkdiv=%h tick=%h wrap=%b required 0/0/0", cd32, tk32, wr32);
    end
    step();
    total++;
    if (cd32 !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold clkdiv=%h want=0", cd32);
    end
    rst32 = 1'b1;
    step();
    total++;
    if (cd32 !== 32'h1) begin
      bad++;
      $display("FAIL release_first got=%h want=1", cd32);
    end
  endtask

  task automatic test_wrap4();
    reset_all();
    repeat (15) step();
    total++;
    if (cd4 !== 4'hF || wr4 !== 1'b0 || tk4 !== 4'h1) begin
      bad++;
      $display("FAIL wrap4_pre clkdiv=%h wrap=%b tick=%h want F/0/1", cd4, wr4, tk4);
    end
    step();
    total++;
    if (cd4 !== 4'h0 || wr4 !== 1'b1 || tk4 !== 4'h0) begin
      bad++;
      $display("FAIL wrap4_roll clkdiv=%h wrap=%b tick=%h want 0/1/0", cd4, wr4, tk4);
    end
    step();
    total++;
    if (cd4 !== 4'h1 || wr4 !== 1'b0) begin
      bad++;
      $display("FAIL wrap4_post clkdiv=%h wrap=%b want 1/0", cd4, wr4);
    end
  endtask

  task automatic test_wrap8();
    int wraps;
    reset_all();
    wraps = 0;
    for (int n = 1; n <= 272; n++) begin
      step();
      if (wr8 === 1'b1) wraps++;
      total++;
      if (cd8 !== 8'(n % 256)) begin
        bad++;
        $display("FAIL wrap8_seq got=%h want=%h", cd8, n % 256);
      end
      if (n == 256) begin
        total++;
        if (wr8 !== 1'b1 || tk8 !== 8'h00) begin
          bad++;
          $display("FAIL wrap8_roll wrap=%b tick=%h want 1/00", wr8, tk8);
        end
      end
      if (n == 257) begin
        total++;
        if (wr8 !== 1'b0 || tk8 !== 8'h01) begin
          bad++;
          $display("FAIL wrap8_post wrap=%b tick=%h want 0/01", wr8, tk8);
        end
      end
      if (n == 128) begin
        total++;
        if (tk8 !== 8'h80) begin
          bad++;
          $display("FAIL tick8_msb got=%h want=80", tk8);
        end
      end
    end
    total++;
    if (wraps != 1) begin
      bad++;
      $display("FAIL wrap8_count got=%0d want=1", wraps);
    end
  endtask

  task automatic test_long32();
    reset_all();
    for (int n = 1; n <= 65537; n++) begin
      step();
      total++;
      if (cd32 !== 32'(n) || wr32 !== 1'b0) begin
        bad++;
        $display("FAIL long32 got=%h wrap=%b want=%h wrap=0", cd32, wr32, n);
      end
      if (n == 256 || n == 4096 || n == 65536) begin
        total++;
        if (tk32 !== 32'(n)) begin
          bad++;
          $display("FAIL long32_tick got=%h want=%h", tk32, n);
        end
      end
    end
  endtask

  task automatic test_short_reset();
    repeat (5) step();
    rst32 = 1'b0;
    #1;
    total++;
    if (cd32 !== 32'h0) begin
      bad++;
      $display("FAIL short_reset_clear got=%h want=0", cd32);
    end
    #2;
    rst32 = 1'b1;
    #1;
    total++;
    if (cd32 !== 32'h0) begin
      bad++;
      $display("FAIL short_reset_hold got=%h want=0", cd32);
    end
    step();
    total++;
    if (cd32 !== 32'h1) begin
      bad++;
      $display("FAIL short_reset_first got=%h want=1", cd32);
    end
    step();
    total++;
    if (cd32 !== 32'h2) begin
      bad++;
      $display("FAIL short_reset_second got=%h want=2", cd32);
    end
  endtask

  initial begin
    test_reset();
    test_count10();
    test_period();
    test_mid_reset();
    test_wrap4();
    test_wrap8();
    test_long32();
    test_short_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clkdiv_counter.md
Name: clkdiv_counter

Overview:
- Free-running binary up-counter that supplies a bank of power-of-two divided clocks to the rest of the design.
- Bit i of the counter is a 50% duty square wave at f_clk / 2^(i+1).
- Audio tone generators and display/scan logic tap individual bits, or use the provided edge strobes.
- One instance per clock domain; purely synchronous to clk apart from reset.

Parameters:
- WIDTH, 32, counter width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately, independent of clk.
- clkdiv  output  WIDTH  current counter value; bit i = clk divided by 2^(i+1).
- tick  output  WIDTH  per-bit rise strobes (combinational decode of clkdiv).
- wrap  output  1  registered one-cycle pulse on counter roll-over.

Behaviour:
- Reset (rst=0, asynchronous assert):
  - clkdiv=0, wrap=0.
  - tick follows the decode of clkdiv=0, so tick=0.
  - Outputs hold while rst stays low; clk edges are ignored.
- Reset release: synchronous to clk in effect. The first rising edge with rst=1 loads clkdiv=1.
- Counting: each rising clk with rst=1, clkdiv <= clkdiv + 1, modulo 2^WIDTH.
  - No enable, no load, no saturation.
  - All-ones wraps to 0 on the next edge.
- Divided-clock property:
  - clkdiv[i] toggles exactly every 2^i clk cycles.
  - Period is 2^(i+1) cycles, high and low phases equal.
  - clkdiv[0] toggles every cycle.
- tick[i] (combinational):
  - tick[i] = clkdiv[i] & (clkdiv[i-1:0] == 0); tick[0] = clkdiv[0].
  - High for exactly the one cycle immediately after bit i rises 0->1.
  - Must be glitch-free relative to sampling on the next clk edge.
- wrap (registered):
  - Set to 1 on the edge where clkdiv goes from all-ones to 0.
  - Cleared to 0 on every other edge.
  - Never set by reset itself.
- Reset mid-count: any value returns to 0 immediately. A wrap pulse in flight is cleared.
- No multicycle paths. The incrementer must close timing at full WIDTH in a single cycle, using a carry chain or pipelined-free lookahead as the technology requires.
- Implementation structure:
  - Count register, with incrementer split into 8-bit carry-select segments for WIDTH > 16.
  - tick decode generated per bit.
  - wrap register.
  - Parameter legality check (elaboration error if WIDTH < 2 or > 64).

Test Plan:
- Assert rst=0 mid-count (clkdiv=0x1234), no clk edge -> clkdiv=0, wrap=0, tick=0 immediately.
- Release rst, apply 10 clocks -> clkdiv reads 1,2,...,10 after each edge; tick[0] high on odd values; tick[1] high at 2, 6, 10; tick[2] high at 4.
- Run 64 clocks from reset -> clkdiv[3] period measured 16 cycles, 8 high / 8 low; clkdiv[0] toggles every cycle.
- WIDTH=4 instance, clock 15 edges to 0xF, then 1 more -> clkdiv=0 and wrap=1 for exactly one cycle. Next edge clkdiv=1, wrap=0.
- WIDTH=32, force the count near 0xFFFFFFFE via a reset-free long run in a fast-forward model, or use a WIDTH=8 proxy -> 0xFE,0xFF,0x00 sequence; wrap pulses once; tick bus is all zero at 0x00.
- Pulse rst low for less than one clk period between edges -> count clears asynchronously and resumes from 1 on the first edge after release.
